activation_rd_req_ctrl: RTL
===========================

Name: activation_rd_req_ctrl

Overview:
- Read-request sequencer for the activation (GELU) layer.
- Walks the input feature map (channel-group, row) and issues MCIF read requests; each request fetches one row of pixels. One pixel is one beat of MAX_DAT_DW*Tout bits.
- Throttles issue against the read-response FIFO depth, using the FIFO pop strobe returned by the dat2buf stage.
- Reports a done pulse once all data has been requested and consumed.

Parameters:
- ADDR_W, 32, byte-address width.
- LEN_W, 8, request length field width (len = beats-1).
- FIFO_DEPTH, 64, response FIFO entries (beats); bounds outstanding beats.
- CNT_W, 16, width of the w/h/channel loop counters.
- BEAT_BYTES, 32, bytes per beat (MAX_DAT_DW*Tout/8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle launch pulse from CSR.
- base_addr  in  ADDR_W  feature-map start byte address.
- line_stride  in  ADDR_W  byte offset between consecutive rows.
- surface_stride  in  ADDR_W  byte offset between consecutive Tout-channel groups.
- ch_div_tout  in  CNT_W  number of channel groups.
- h_in  in  CNT_W  rows per group.
- w_in  in  CNT_W  pixels per row.
- rd_req_vld  out  1  request valid.
- rd_req_rdy  in  1  MCIF accepts request.
- rd_req_addr  out  ADDR_W  request byte address.
- rd_req_len  out  LEN_W  beats-1.
- rd_fifo_pop  in  1  one response beat consumed downstream.
- busy  out  1  job active.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  sticky configuration/underflow error, cleared by start.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters, outstanding=0, address registers=0.
- Configuration inputs are sampled on start; later changes to them are ignored until the next start.
- FSM states:
  - IDLE: on start go to CHECK; busy=1 from the next cycle.
  - CHECK (1 cycle): if ch_div_tout, h_in or w_in is 0, go to FIN with no requests issued. If w_in exceeds the single-request limit (see Optional Feature), set cfg_err and go to FIN. Otherwise go to REQ.
  - REQ: request is driven from registered addr/len.
    - rd_req_vld=1 only if outstanding + len + 1 <= FIFO_DEPTH.
    - Once vld is asserted, addr and len stay stable until rd_req_rdy.
    - On handshake, advance the loops: w-segment (split mode only), then h, then ch.
    - Address update: row_addr += line_stride; at h wrap, grp_addr += surface_stride and row_addr = grp_addr (new value).
    - After the last request's handshake go to DRAIN.
  - DRAIN: wait until outstanding==0, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Outstanding counter (width log2(FIFO_DEPTH)+1):
  - +len+1 on request handshake; -1 on rd_fifo_pop.
  - Both in the same cycle: net +len.
- rd_fifo_pop while outstanding==0: counter holds at 0 and cfg_err is set.
- start while busy: ignored.
- Synchronous rst mid-job: drops vld and busy immediately, with no done pulse.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Issue rate: at most one request per cycle; back-to-back issue is allowed when credit suffices.
- Latency: start to first rd_req_vld = 2 cycles (start → CHECK → REQ), assuming credit is available.

Optional Feature:
- Macro: ACT_RD_SPLIT_EN.
- Defined:
  - Rows are split into ceil(w_in/MAX_BURST) requests, with MAX_BURST = min(2^LEN_W, FIFO_DEPTH).
  - Segment address advances by MAX_BURST*BEAT_BYTES; the last segment has len = remainder-1.
  - Any w_in >= 1 is legal.
- Undefined:
  - One request per row, len = w_in-1.
  - w_in > MAX_BURST → cfg_err set and job finishes without requests.

Decomposition:
- Shared package/defines header holds:
  - FSM state encoding (IDLE, CHECK, REQ, DRAIN, FIN);
  - MAX_BURST derivation;
  - request payload packing {addr,len};
  - existing CNN_defines widths (log2_CH, log2_H, log2_W).
- One sub-module: act_rd_credit_cnt — the outstanding-beat counter, with an add/sub interface and a can_issue(len) comparison output.

Test Plan:
- ch=2, h=3, w=16, base=0x1000, line=0x200, surf=0x800, rdy=1, pop per beat → 6 requests at 0x1000/0x1200/0x1400/0x1800/0x1A00/0x1C00, len=15, single done after 96 pops.
- FIFO_DEPTH=64, w=40, no pops initially → 1st request issued; 2nd stalls (40+40>64) until 16 pops; addr/len stable while stalled.
- rdy held low 10 cycles mid-job → vld, addr, len unchanged throughout; no loop advance.
- h_in=0 → zero requests, done pulse 3 cycles after start, cfg_err=0.
- Split disabled, w=300, LEN_W=8 → cfg_err=1, done, no requests. Split enabled, FIFO_DEPTH=128, w=300 → per row: len 127, 127, 43, addr steps 128*BEAT_BYTES.
- Same-cycle request handshake (len=7) + pop → outstanding +7. rst mid-REQ → busy=0, vld=0 next cycle, no done. Stray pop when idle → cfg_err=1.

Source files
------------

// File: rtl/activation_rd_req_ctrl_pkg.sv
// Shared types and constants for the activation (GELU) read-request sequencer.
// Row splitting into several requests is enabled by defining ACT_RD_SPLIT_EN.
package activation_rd_req_ctrl_pkg;

  localparam int log2_CH = 16;
  localparam int log2_H  = 16;
  localparam int log2_W  = 16;
  localparam int CNN_CNT_W = (log2_CH > log2_H) ? ((log2_CH > log2_W) ? log2_CH : log2_W)
                                                : ((log2_H > log2_W) ? log2_H : log2_W);

  localparam int RD_ADDR_W = 32;
  localparam int RD_LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_DRAIN,
    ST_FIN
  } rd_state_t;

  // MCIF request payload, packed as {addr, len}
  typedef struct packed {
    logic [RD_ADDR_W-1:0] addr;
    logic [RD_LEN_W-1:0]  len;
  } rd_req_t;

  // Longest burst one request may carry: limited by the len field and by the FIFO
  function automatic int max_burst(input int len_w, input int fifo_depth);
    int lim;
    lim = 1 << len_w;
    return (lim < fifo_depth) ? lim : fifo_depth;
  endfunction

endpackage

// File: rtl/activation_rd_req_ctrl_credit.sv
// Outstanding-beat counter for the read-response FIFO; reports whether a request
// of a given len still fits and flags pops that arrive with nothing outstanding.
module act_rd_credit_cnt #(
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          add,
  input  logic                          sub,
  input  logic [LEN_W-1:0]              len,
  output logic                          can_issue,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = ((CW > LEN_W) ? CW : LEN_W) + 2;

  logic [SW-1:0] need;

  assign need      = SW'(outstanding) + SW'(len) + SW'(1);
  assign can_issue = (need <= SW'(FIFO_DEPTH));
  assign underflow = sub && !add && (outstanding == '0);

  // A request adds len+1 beats; a simultaneous pop nets out one of them
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (add && sub) begin
      outstanding <= outstanding + CW'(len);
    end else if (add) begin
      outstanding <= outstanding + CW'(len) + CW'(1);
    end else if (sub && (outstanding != '0)) begin
      outstanding <= outstanding - CW'(1);
    end
  end

endmodule

// File: rtl/activation_rd_req_ctrl.sv
// Activation read-request sequencer: walks channel groups and rows, issuing one MCIF
// read per row under FIFO credit. Define ACT_RD_SPLIT_EN to split wide rows into bursts.
module activation_rd_req_ctrl
  import activation_rd_req_ctrl_pkg::*;
#(
  parameter int ADDR_W     = RD_ADDR_W,
  parameter int LEN_W      = RD_LEN_W,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = CNN_CNT_W,
  parameter int BEAT_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [ADDR_W-1:0] surface_stride,
  input  logic [CNT_W-1:0]  ch_div_tout,
  input  logic [CNT_W-1:0]  h_in,
  input  logic [CNT_W-1:0]  w_in,
  output logic              rd_req_vld,
  input  logic              rd_req_rdy,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [LEN_W-1:0]  rd_req_len,
  input  logic              rd_fifo_pop,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int MAX_BURST = max_burst(LEN_W, FIFO_DEPTH);

  rd_state_t state_q, state_d;

  logic [CNT_W-1:0]  ch_q, h_q, w_q, ch_cnt, h_cnt;
  logic [ADDR_W-1:0] line_q, surf_q, grp_addr, row_addr, row_next;
  rd_req_t           req_q;
  logic              cfg_err_q, done_q;
  logic              cfg_zero, w_too_big, h_last, ch_last, row_last, last_req;
  logic              hs, can_issue, underflow;
  logic [LEN_W-1:0]  first_len;
  logic [$clog2(FIFO_DEPTH):0] outstanding;

`ifdef ACT_RD_SPLIT_EN
  localparam logic [ADDR_W-1:0] SEG_BYTES = ADDR_W'(MAX_BURST * BEAT_BYTES);
  logic [CNT_W-1:0] w_rem;

  function automatic logic [LEN_W-1:0] seg_len(input logic [CNT_W-1:0] rem);
    if (32'(rem) >= 32'(MAX_BURST)) return LEN_W'(MAX_BURST - 1);
    else return LEN_W'(rem - 1'b1);
  endfunction

  assign w_too_big = 1'b0;
  assign first_len = seg_len(w_q);
  assign row_last  = (32'(w_rem) <= 32'(MAX_BURST));
`else
  assign w_too_big = (32'(w_q) > 32'(MAX_BURST));
  assign first_len = LEN_W'(w_q - 1'b1);
  assign row_last  = 1'b1;
`endif

  assign cfg_zero = (ch_q == '0) || (h_q == '0) || (w_q == '0);
  assign h_last   = (h_cnt == h_q - 1'b1);
  assign ch_last  = (ch_cnt == ch_q - 1'b1);
  assign last_req = row_last && h_last && ch_last;
  assign row_next = h_last ? (grp_addr + surf_q) : (row_addr + line_q);

  assign rd_req_vld  = (state_q == ST_REQ) && can_issue;
  assign hs          = rd_req_vld && rd_req_rdy;
  assign rd_req_addr = req_q.addr;
  assign rd_req_len  = req_q.len;
  assign busy        = (state_q == ST_CHECK) || (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

  act_rd_credit_cnt #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .add         (hs),
    .sub         (rd_fifo_pop),
    .len         (req_q.len),
    .can_issue   (can_issue),
    .underflow   (underflow),
    .outstanding (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: state_d = (cfg_zero || w_too_big) ? ST_FIN : ST_REQ;
      ST_REQ:   if (hs && last_req) state_d = ST_DRAIN;
      ST_DRAIN: if (outstanding == '0) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request payload only moves on a handshake, so addr/len hold while vld waits
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q      <= '0;
      h_q       <= '0;
      w_q       <= '0;
      line_q    <= '0;
      surf_q    <= '0;
      grp_addr  <= '0;
      row_addr  <= '0;
      ch_cnt    <= '0;
      h_cnt     <= '0;
      req_q     <= '0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef ACT_RD_SPLIT_EN
      w_rem     <= '0;
`endif
    end else begin
      done_q <= (state_q == ST_FIN);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ch_q      <= ch_div_tout;
            h_q       <= h_in;
            w_q       <= w_in;
            line_q    <= line_stride;
            surf_q    <= surface_stride;
            grp_addr  <= base_addr;
            row_addr  <= base_addr;
            ch_cnt    <= '0;
            h_cnt     <= '0;
            cfg_err_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          req_q.addr <= row_addr;
          req_q.len  <= first_len;
`ifdef ACT_RD_SPLIT_EN
          w_rem      <= w_q;
`endif
          if (!cfg_zero && w_too_big) cfg_err_q <= 1'b1;
        end
        ST_REQ: begin
          if (hs) begin
`ifdef ACT_RD_SPLIT_EN
            if (!row_last) begin
              w_rem      <= w_rem - CNT_W'(MAX_BURST);
              req_q.addr <= req_q.addr + SEG_BYTES;
              req_q.len  <= seg_len(w_rem - CNT_W'(MAX_BURST));
            end else begin
              w_rem      <= w_q;
`else
            begin
`endif
              req_q.len  <= first_len;
              req_q.addr <= row_next;
              row_addr   <= row_next;
              if (h_last) begin
                h_cnt    <= '0;
                ch_cnt   <= ch_cnt + 1'b1;
                grp_addr <= grp_addr + surf_q;
              end else begin
                h_cnt    <= h_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
      if (underflow) cfg_err_q <= 1'b1;
    end
  end

endmodule
